// File: rtl/reset_gen.sv
// Alpha68k reset sequencer: stretches RESET into a power-on hold, and turns each accepted
// watchdog timeout into a fixed-length system reset that also reloads the watchdog.
module reset_gen #(
    parameter int CNT_W      = 16,
    parameter int POR_CYCLES = 1024,
    parameter int WD_CYCLES  = 256
) (
    input  logic       SNKCLK11,
    input  logic       RESET,
    input  logic       nWDRESET,
    input  logic       WD_EN,
    output logic       nPSTRESET,
    output logic       nSYSRESET,
    output logic [7:0] WD_COUNT,
    output logic [1:0] STATE
);

    localparam logic [1:0] ST_POR    = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_WDHOLD = 2'd2;

    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(WD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       wd_count_q, wd_count_d;
    logic             rel_q, rel_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             wd_rise;

    // Only a fresh 0->1 of the synchronised timeout counts; a held-low line never retriggers.
    assign wd_rise = sync2_q & ~prev_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wd_count_d = wd_count_q;
        case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (WD_EN && wd_rise) begin
                    state_d = ST_WDHOLD;
                    cnt_d   = '0;
                    if (wd_count_q != 8'hFF) begin
                        wd_count_d = wd_count_q + 8'd1;
                    end
                end
            end
            ST_WDHOLD: begin
                if (cnt_q == WD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
            end
        endcase
        rel_d = (state_d == ST_RUN);
    end

    always_ff @(posedge SNKCLK11 or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_POR;
            cnt_q      <= '0;
            wd_count_q <= 8'd0;
            rel_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_count_q <= wd_count_d;
            rel_q      <= rel_d;
            sync1_q    <= ~nWDRESET;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
        end
    end

    // Both resets share one register so they release on the same edge.
    assign nPSTRESET = rel_q;
    assign nSYSRESET = rel_q;
    assign WD_COUNT  = wd_count_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen: directed scenarios plus random watchdog traffic, checked each edge
// against a hold-window model built from the sampled nWDRESET history.
module tb_reset_gen;

    localparam int POR = 8;
    localparam int WD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       nwd;
    logic       wd_en;
    logic       npst;
    logic       nsys;
    logic [7:0] wd_count;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;

    reset_gen #(.CNT_W(16), .POR_CYCLES(POR), .WD_CYCLES(WD)) dut (
        .SNKCLK11 (clk),
        .RESET    (rst),
        .nWDRESET (nwd),
        .WD_EN    (wd_en),
        .nPSTRESET(npst),
        .nSYSRESET(nsys),
        .WD_COUNT (wd_count),
        .STATE    (state)
    );

    always #5 clk = ~clk;

    // Model: edge index since release, the nWDRESET level seen at each edge, and the
    // edge number from which the resets are released.
    bit samp[$];
    int e;
    int hold_end;
    bit in_por;
    int exp_count;

    function automatic bit samp_at(int i);
        return (i < 1) ? 1'b1 : samp[i-1];
    endfunction

    task automatic model_reset();
        samp.delete();
        e         = 0;
        hold_end  = POR;
        in_por    = 1'b1;
        exp_count = 0;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic check_model();
        bit          run;
        logic [7:0]  exp_state;
        run       = (e >= hold_end);
        exp_state = run ? 8'd1 : (in_por ? 8'd0 : 8'd2);
        check("nSYSRESET", {7'd0, nsys}, {7'd0, run});
        check("nPSTRESET", {7'd0, npst}, {7'd0, run});
        check("WD_COUNT", wd_count, 8'(exp_count));
        check("STATE", {6'd0, state}, exp_state);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_nSYS"}, {7'd0, nsys}, 8'd0);
        check({tag, "_nPST"}, {7'd0, npst}, 8'd0);
        check({tag, "_CNT"}, wd_count, 8'd0);
        check({tag, "_STATE"}, {6'd0, state}, 8'd0);
    endtask

    task automatic tick(input bit n, input bit en);
        bit rise;
        nwd   = n;
        wd_en = en;
        @(posedge clk);
        e++;
        samp.push_back(n);
        // A timeout is seen two edges after it is first sampled low, if the prior sample was high.
        rise = !samp_at(e - 2) && samp_at(e - 3);
        if ((e - 1) >= hold_end && en && rise) begin
            hold_end = e + WD;
            if (exp_count < 255) exp_count++;
        end
        if (e >= hold_end) in_por = 1'b0;
        #1;
        check_model();
    endtask

    task automatic timeout_pulse(input int low_len, input int high_len);
        repeat (low_len) tick(1'b0, 1'b1);
        repeat (high_len) tick(1'b1, 1'b1);
    endtask

    initial begin
        bit r_n;
        bit r_en;
        rst   = 1'b1;
        nwd   = 1'b1;
        wd_en = 1'b1;
        #3;
        check_reset_vals("por_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por_held");
        rst = 1'b0;
        model_reset();

        // Power-on hold then release into RUN.
        repeat (12) tick(1'b1, 1'b1);

        // Single 3-edge timeout.
        timeout_pulse(3, 8);

        // Stuck low: one event only, then a fresh fall gives a second.
        timeout_pulse(20, 4);
        timeout_pulse(3, 8);

        // Watchdog ignored while disabled.
        repeat (2) tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0);

        // Saturation of the accepted-event counter, with the hold still produced.
        repeat (262) timeout_pulse(3, 6);

        // Random traffic, including events arriving during holds.
        r_n  = 1'b1;
        r_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r_n = ~r_n;
            if ($urandom_range(0, 15) == 0) r_en = ~r_en;
            tick(r_n, r_en);
        end

        // Reset two edges into a hold: immediate, edge-free return to reset values.
        repeat (6) tick(1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("mid_hold_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("mid_hold_held");
        rst = 1'b0;
        model_reset();
        repeat (12) tick(1'b1, 1'b1);
        timeout_pulse(3, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
